data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: takes single-word CPU read/write requests and drives a
// simple data memory port. Each transfer is a fixed sequence:
// SETUP (address/data stable, no strobe), ACCESS (WAIT_CYCLES long,
// write strobe in the first cycle only), then DONE. An out-of-range
// address goes to ERR and never touches the memory.
// Every output comes straight from a flop. Each output's next value is
// computed from the next FSM state, so the outputs line up with the state.
module data_mem_ctrl #(
  parameter int DATA_MEM_ADDR_WIDTH = 16,
  parameter int DATA_MEM_WIDTH      = 16,
  parameter int DATA_MEM_SIZE       = 3,
  parameter int WAIT_CYCLES         = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           we,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_MEM_WIDTH-1:0]      wdata,
  output logic                           ready,
  output logic                           done,
  output logic [DATA_MEM_WIDTH-1:0]      rdata,
  output logic                           exception,
  output logic                           exc_sticky,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_MEM_WIDTH-1:0]      mem_data_in,
  output logic                           mem_write,
  input  logic [DATA_MEM_WIDTH-1:0]      mem_data_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [3:0]                     CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [DATA_MEM_ADDR_WIDTH-1:0] MEM_SIZE = DATA_MEM_ADDR_WIDTH'(DATA_MEM_SIZE);

  logic [2:0]                     state_q, state_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic                           we_q, we_d;
  logic                           ready_q, ready_d;
  logic                           done_q, done_d;
  logic                           exception_q, exception_d;
  logic                           exc_sticky_q, exc_sticky_d;
  logic                           mem_write_q, mem_write_d;
  logic [DATA_MEM_WIDTH-1:0]      rdata_q, rdata_d;
  logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_MEM_WIDTH-1:0]      mem_data_in_q, mem_data_in_d;

  // Full-width unsigned compare: a large address must never alias into range.
  logic in_range;
  assign in_range = (addr < MEM_SIZE);

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    exc_sticky_d  = exc_sticky_q;
    rdata_d       = rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    done_d        = 1'b0;
    exception_d   = 1'b0;
    mem_write_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d = we;
          if (in_range) begin
            // mem_addr/mem_data_in double as the latched request and are
            // only updated for legal addresses, so memory never sees a bad one.
            state_d       = S_SETUP;
            mem_addr_d    = addr;
            mem_data_in_d = wdata;
          end else begin
            state_d      = S_ERR;
            done_d       = 1'b1;
            exception_d  = 1'b1;
            exc_sticky_d = 1'b1;
            rdata_d      = '0;
          end
        end
      end
      S_SETUP: begin
        state_d     = S_ACCESS;
        cnt_d       = CNT_LOAD;
        mem_write_d = we_q;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!we_q) rdata_d = mem_data_out;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      we_q          <= 1'b0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      exception_q   <= 1'b0;
      exc_sticky_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      rdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      exception_q   <= exception_d;
      exc_sticky_q  <= exc_sticky_d;
      mem_write_q   <= mem_write_d;
      rdata_q       <= rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign exception   = exception_q;
  assign exc_sticky  = exc_sticky_q;
  assign mem_write   = mem_write_q;
  assign rdata       = rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: default-parameter instance checked by a
// done/mem_write scoreboard, plus a WAIT_CYCLES=3 instance for the long
// access case.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [15:0] addr, wdata;
  logic        ready, done, exception, exc_sticky, mem_write;
  logic [15:0] rdata, mem_addr, mem_data_in, mem_data_out;

  logic        req3, we3;
  logic [15:0] addr3, wdata3;
  logic        ready3, done3, exc3, sticky3, mem_write3;
  logic [15:0] rdata3, mem_addr3, mem_data_in3, mem_data_out3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int e0;
  int prev_e0;

  typedef struct { logic [15:0] rdata; logic exc; int done_cyc; } exp_t;
  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  logic [15:0] mem [0:3];
  logic [15:0] ref_mem [0:3];
  logic [15:0] last_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .exception(exception),
    .exc_sticky(exc_sticky), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  data_mem_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .ready(ready3), .done(done3), .rdata(rdata3), .exception(exc3),
    .exc_sticky(sticky3), .mem_addr(mem_addr3), .mem_data_in(mem_data_in3),
    .mem_write(mem_write3), .mem_data_out(mem_data_out3)
  );

  // Data memory model for the main instance.
  assign mem_data_out = mem[mem_addr[1:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[1:0]] <= mem_data_in;

  // Time-varying read data exposes exactly which edge captures rdata.
  assign mem_data_out3 = mem_addr3 + cyc[15:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse and every write strobe must match a queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", cyc + 1, e.done_cyc);
          chk("rdata", rdata, e.rdata);
          chk("exception", exception, e.exc);
        end
      end
      if (mem_write) begin
        if (wr_q.size() == 0) chk("unexpected_mem_write", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_mem_addr", mem_addr, w.a);
          chk("wr_mem_data_in", mem_data_in, w.d);
        end
      end
    end
  end

  task automatic check_reset();
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_exception", exception, 1'b0);
    chk("rst_exc_sticky", exc_sticky, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_data_in", mem_data_in, 16'h0);
  endtask

  // Issue one transfer when ready and queue its expected response.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input logic hold);
    int   n;
    exp_t e;
    wr_t  wr;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin @(negedge clk); n++; end
    chk("issue_ready_wait", ready, 1'b1);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    e0 = cyc;
    if (a >= 16'd3) begin
      e.rdata = 16'h0; e.exc = 1'b1; e.done_cyc = e0 + 1;
      last_rdata = 16'h0;
    end else begin
      e.exc = 1'b0; e.done_cyc = e0 + 3;
      if (w) begin
        ref_mem[a[1:0]] = d;
        e.rdata = last_rdata;
        wr.a = a; wr.d = d;
        wr_q.push_back(wr);
      end else begin
        last_rdata = ref_mem[a[1:0]];
        e.rdata = last_rdata;
      end
    end
    exp_q.push_back(e);
    // Held req: scribble an out-of-range write while busy; it must be ignored.
    if (hold) begin we = 1'b1; addr = 16'h0003; wdata = 16'hdead; end
    else req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_wr_q", wr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_seen, done_cnt;
    logic [15:0] rd3;
    mem[0] = 16'h2bcd; mem[1] = 16'h0000; mem[2] = 16'h5a5a; mem[3] = 16'h0000;
    for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
    last_rdata = 16'h0;
    req3 = 1'b0; we3 = 1'b0; addr3 = 16'h0; wdata3 = 16'h0;
    // Reset with a request present: it must be ignored.
    rst = 1'b0; req = 1'b1; we = 1'b1; addr = 16'h0001; wdata = 16'hffff;
    repeat (3) @(negedge clk);
    check_reset();
    req = 1'b0; rst = 1'b1;

    issue(1'b0, 16'h0000, 16'h0000, 1'b0);   // read preloaded 2bcd
    issue(1'b1, 16'h0001, 16'h1234, 1'b0);   // write, rdata must hold
    issue(1'b0, 16'h0001, 16'h0000, 1'b0);   // read back 1234
    issue(1'b0, 16'h0002, 16'h0000, 1'b0);   // highest legal address
    issue(1'b0, 16'h0003, 16'h0000, 1'b0);   // first illegal address
    issue(1'b1, 16'h0100, 16'h7777, 1'b0);   // illegal only in the upper bits
    drain();
    chk("exc_sticky_held", exc_sticky, 1'b1);
    issue(1'b1, 16'h0002, 16'h0f0f, 1'b0);
    issue(1'b0, 16'h0002, 16'h0000, 1'b0);
    drain();
    chk("exc_sticky_still", exc_sticky, 1'b1);

    // Back-to-back with req held high: one acceptance every 4 cycles.
    issue(1'b0, 16'h0000, 16'h0000, 1'b1); prev_e0 = e0;
    issue(1'b0, 16'h0002, 16'h0000, 1'b1); chk("issue_interval", e0 - prev_e0, 4); prev_e0 = e0;
    issue(1'b0, 16'h0000, 16'h0000, 1'b1); chk("issue_interval", e0 - prev_e0, 4); prev_e0 = e0;
    issue(1'b0, 16'h0002, 16'h0000, 1'b0); chk("issue_interval", e0 - prev_e0, 4);
    drain();

    // Reset during the ACCESS cycle of a write.
    begin
      wr_t wr;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 16'h0001; wdata = 16'hbeef;
      @(posedge clk); #1;
      req = 1'b0;
      wr.a = 16'h0001; wr.d = 16'hbeef;
      wr_q.push_back(wr);
      ref_mem[1] = 16'hbeef;   // strobe is already high in ACCESS, so the write lands
      @(negedge clk);          // SETUP
      @(negedge clk);          // ACCESS, strobe checked by monitor
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_abort_ready", ready, 1'b1);
      last_rdata = 16'h0;
      issue(1'b0, 16'h0001, 16'h0000, 1'b0);
      drain();
    end

    // WAIT_CYCLES=3 instance: read addr 2.
    @(negedge clk);
    chk("w3_ready", ready3, 1'b1);
    req3 = 1'b1; we3 = 1'b0; addr3 = 16'h0002;
    @(posedge clk); #1;
    e0 = cyc;
    req3 = 1'b0; addr3 = 16'h0001;
    done_seen = -1; done_cnt = 0; rd3 = 16'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 4) chk("w3_mem_addr_stable", mem_addr3, 16'h0002);
      if (mem_write3) chk("w3_mem_write", mem_write3, 1'b0);
      if (done3) begin done_cnt++; done_seen = cyc; rd3 = rdata3; end
    end
    chk("w3_done_cycle", done_seen + 1, e0 + 5);
    chk("w3_done_pulses", done_cnt, 1);
    chk("w3_rdata", rd3, 16'(2 + e0 + 3));
    chk("w3_exception", sticky3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
